ps2_kbd_decode: RTL and testbench
=================================

# ps2_kbd_decode

Scancode decoder between the PS/2 byte receiver (`ps2_keyboard`) and the display/LED consumers. Pops bytes from the receiver FIFO with its `nextdata_n` handshake and tracks make/break (`F0`) and extended (`E0`) prefixes. Presents the currently held key, its ASCII value and a running press count for the seven-segment and LED logic. Typematic repeats are suppressed.

## Interface
- `CNT_W`, default 8: width of `press_count`.

- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `kbd_data` in 8: byte at the receiver FIFO head.
- `kbd_ready` in 1: receiver FIFO non-empty.
- `kbd_overflow` in 1: receiver FIFO overflow indication.
- `kbd_nextdata_n` out 1: active-low pop strobe to receiver; exactly one cycle per byte.
- `key_code` out 8: scancode of held or last-held key.
- `key_ext` out 1: held key had `E0` prefix.
- `key_ascii` out 8: ASCII of `key_code`.
- `key_valid` out 1: a key is currently held.
- `press_pulse` out 1: one-cycle strobe on each new press.
- `press_count` out CNT_W: number of new presses, wraps.
- `ovf_sticky` out 1: receiver overflow seen since reset.

## Operation
- FSM states: IDLE, ACK, WAIT.
  - IDLE with `kbd_ready`=1: latch `kbd_data`, process it (rules below), go to ACK.
  - ACK: `kbd_nextdata_n`=0, go to WAIT.
  - WAIT: ignore `kbd_ready`, go to IDLE.
- Byte processing:
  - `F0`: set `brk` flag.
  - `E0`: set `ext` flag.
  - Other byte with `brk`=1 (release): if byte equals `key_code` and `ext` equals `key_ext`, clear `key_valid`. Otherwise no output change. Clear `brk` and `ext`.
  - Other byte with `brk`=0 (make), same key already held (`key_valid`=1, byte equals `key_code`, `ext` equals `key_ext`): typematic repeat. No output change. Clear `ext`.
  - Other make byte: load `key_code`=byte and `key_ext`=`ext`, set `key_valid`=1, pulse `press_pulse`, increment `press_count` (wraps modulo 2^CNT_W). Clear `ext`.
  - A new make while another key is held replaces it; the old key's later break does not match and is ignored.
- `ovf_sticky` is set on any cycle with `kbd_overflow`=1. Only reset clears it.
- `key_code` and `key_ext` are retained after release.

## Timing
- Reset values: state IDLE, `kbd_nextdata_n`=1, `key_code`=0, `key_ext`=0, `key_ascii`=0, `key_valid`=0, `press_pulse`=0, `press_count`=0, `ovf_sticky`=0, `brk`=0, `ext`=0.
- All outputs are registered.
- Byte processing updates the outputs at the edge that samples `kbd_ready` in IDLE (cycle N); they are visible in N+1.
- `kbd_nextdata_n` is low during N+1 only.
- WAIT occupies N+2. The next byte is sampled no earlier than N+3: 3-cycle minimum per byte.
- `press_pulse` is high exactly during N+1.
- `kbd_ready` dropping during ACK or WAIT has no effect.
- Reset asserted mid-sequence forces all reset values immediately, including `kbd_nextdata_n`=1. A pending prefix is lost.

## Configuration
- `KBD_ASCII_EN` defined: `key_ascii` is registered together with `key_code` from a lookup.
  - `1C`..: letters map to lowercase `a`–`z` (0x61–0x7A).
  - Digit row maps to `0`–`9` (`45`→0x30, `16`→0x31, …).
  - `29`→0x20, `5A`→0x0D, `66`→0x08.
  - `key_ext`=1 or unmapped code → 0x00.
- `KBD_ASCII_EN` undefined: no lookup logic; `key_ascii` is constant 0x00.

## Test plan
- Reset, then bytes `1C`: `key_code`=0x1C, `key_valid`=1, `press_count`=1, one `press_pulse`, `key_ascii`=0x61 (0x00 without `KBD_ASCII_EN`); `kbd_nextdata_n` low exactly 1 cycle.
- `1C 1C 1C F0 1C`: `press_count`=1, single pulse; `key_valid`=0 after the last byte; `key_code` stays 0x1C.
- `E0 75 F0 75`: `key_ext`=1, `key_ascii`=0x00, `key_valid` stays 1 (break lacks `E0`); then `E0 F0 E0 75`… → `E0 F0 75` clears `key_valid`.
- 256 distinct make/break pairs of `16` with CNT_W=8: `press_count` wraps to 0; 256 pulses.
- Hold `kbd_ready`=1 with a continuous stream: one pop every 3 cycles; `kbd_overflow` pulse → `ovf_sticky`=1 until reset.
- Deassert `resetn` during ACK after `F0`: outputs at reset values asynchronously; a following `1C` is a make (count 1).

Source files
------------

// File: rtl/ps2_kbd_decode_if.sv
// rtl/ps2_kbd_decode_if.sv - pop handshake between the PS/2 receiver FIFO and the scancode decoder
interface ps2_kbd_decode_if;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;

    modport master (
        output kbd_data,
        output kbd_ready,
        output kbd_overflow,
        input  kbd_nextdata_n
    );

    modport slave (
        input  kbd_data,
        input  kbd_ready,
        input  kbd_overflow,
        output kbd_nextdata_n
    );
endinterface

// File: rtl/ps2_kbd_decode.sv
// rtl/ps2_kbd_decode.sv - PS/2 scancode decoder: make/break/E0 tracking, held key, press count
// Optional ASCII lookup enabled by defining KBD_ASCII_EN.
module ps2_kbd_decode #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    ps2_kbd_decode_if.slave   kbd,
    output logic [7:0]        key_code,
    output logic              key_ext,
    output logic [7:0]        key_ascii,
    output logic              key_valid,
    output logic              press_pulse,
    output logic [CNT_W-1:0]  press_count,
    output logic              ovf_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_take;
    logic             w_is_f0;
    logic             w_is_e0;
    logic             w_same;
    logic             w_make;

    logic             r_brk;
    logic             r_ext;
    logic             r_nextdata_n;
    logic [7:0]       r_key_code;
    logic             r_key_ext;
    logic             r_key_valid;
    logic             r_press_pulse;
    logic [CNT_W-1:0] r_press_count;
    logic             r_ovf_sticky;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (kbd.kbd_ready) begin
                    w_take      = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK:     w_state_nxt = WAIT;
            WAIT:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A make of the key already held is a typematic repeat and changes nothing.
    always_comb begin
        w_is_f0 = (kbd.kbd_data == 8'hF0);
        w_is_e0 = (kbd.kbd_data == 8'hE0);
        w_same  = (kbd.kbd_data == r_key_code) && (r_ext == r_key_ext);
        w_make  = w_take && !w_is_f0 && !w_is_e0 && !r_brk && !(r_key_valid && w_same);
    end

`ifdef KBD_ASCII_EN
    logic [7:0] r_key_ascii;

    function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic ext);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return ext ? 8'h00 : a;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_key_ascii <= 8'h00;
        end else if (w_make) begin
            r_key_ascii <= f_ascii(kbd.kbd_data, r_ext);
        end
    end

    assign key_ascii = r_key_ascii;
`else
    assign key_ascii = 8'h00;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_brk         <= 1'b0;
            r_ext         <= 1'b0;
            r_nextdata_n  <= 1'b1;
            r_key_code    <= 8'h00;
            r_key_ext     <= 1'b0;
            r_key_valid   <= 1'b0;
            r_press_pulse <= 1'b0;
            r_press_count <= '0;
            r_ovf_sticky  <= 1'b0;
        end else begin
            r_nextdata_n  <= !w_take;
            r_press_pulse <= w_make;
            r_ovf_sticky  <= r_ovf_sticky | kbd.kbd_overflow;
            if (w_take) begin
                if (w_is_f0) begin
                    r_brk <= 1'b1;
                end else if (w_is_e0) begin
                    r_ext <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (r_brk && w_same) begin
                        r_key_valid <= 1'b0;
                    end
                end
            end
            if (w_make) begin
                r_key_code    <= kbd.kbd_data;
                r_key_ext     <= r_ext;
                r_key_valid   <= 1'b1;
                r_press_count <= r_press_count + CNT_W'(1);
            end
        end
    end

    assign kbd.kbd_nextdata_n = r_nextdata_n;
    assign key_code           = r_key_code;
    assign key_ext            = r_key_ext;
    assign key_valid          = r_key_valid;
    assign press_pulse        = r_press_pulse;
    assign press_count        = r_press_count;
    assign ovf_sticky         = r_ovf_sticky;

endmodule

// File: tb/tb_ps2_kbd_decode.sv
// tb/tb_ps2_kbd_decode.sv - scoreboard bench for ps2_kbd_decode (both KBD_ASCII_EN builds)
module tb_ps2_kbd_decode;

    logic       clk;
    logic       resetn;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic       key_valid;
    logic       press_pulse;
    logic [7:0] press_count;
    logic       ovf_sticky;

    ps2_kbd_decode_if kbd_if ();

    ps2_kbd_decode #(.CNT_W(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .kbd         (kbd_if),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_ascii   (key_ascii),
        .key_valid   (key_valid),
        .press_pulse (press_pulse),
        .press_count (press_count),
        .ovf_sticky  (ovf_sticky)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic [7:0] ascii;
        logic [7:0] cnt;
    } press_t;

    press_t     exp_q[$];
    int         n_vec;
    int         n_err;
    int         n_pops;
    int         n_pulses;
    int         cyc;
    logic       prev_low;

    logic       m_brk;
    logic       m_ext;
    logic [7:0] m_code;
    logic       m_kext;
    logic       m_valid;
    logic [7:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [7:0] exp_ascii(input logic [7:0] c, input logic e);
        logic [7:0] a;
        case (c)
            8'h1C: a = "a"; 8'h32: a = "b"; 8'h21: a = "c"; 8'h23: a = "d"; 8'h24: a = "e";
            8'h2B: a = "f"; 8'h34: a = "g"; 8'h33: a = "h"; 8'h43: a = "i"; 8'h3B: a = "j";
            8'h42: a = "k"; 8'h4B: a = "l"; 8'h3A: a = "m"; 8'h31: a = "n"; 8'h44: a = "o";
            8'h4D: a = "p"; 8'h15: a = "q"; 8'h2D: a = "r"; 8'h1B: a = "s"; 8'h2C: a = "t";
            8'h3C: a = "u"; 8'h2A: a = "v"; 8'h1D: a = "w"; 8'h22: a = "x"; 8'h35: a = "y";
            8'h1A: a = "z";
            8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3"; 8'h25: a = "4";
            8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7"; 8'h3E: a = "8"; 8'h46: a = "9";
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        if (e) a = 8'h00;
`ifndef KBD_ASCII_EN
        a = 8'h00;
`endif
        return a;
    endfunction

    task automatic model_reset();
        m_brk = 1'b0; m_ext = 1'b0; m_code = 8'h00; m_kext = 1'b0;
        m_valid = 1'b0; m_cnt = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        press_t p;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (m_brk) begin
            if (b == m_code && m_ext == m_kext) m_valid = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (m_valid && b == m_code && m_ext == m_kext) begin
            m_ext = 1'b0;
        end else begin
            m_code  = b;
            m_kext  = m_ext;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 8'd1;
            p.code  = b; p.ext = m_ext; p.ascii = exp_ascii(b, m_ext); p.cnt = m_cnt;
            exp_q.push_back(p);
            m_ext   = 1'b0;
        end
    endtask

    // Monitor: pops one expected press per observed press_pulse cycle.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_low = 1'b0;
        end else begin
            if (kbd_if.kbd_nextdata_n === 1'b0) begin
                n_pops++;
                n_vec++;
                if (prev_low) begin
                    n_err++;
                    $display("FAIL nextdata_width: low on consecutive cycles, expected single-cycle strobe");
                end
            end
            prev_low = (kbd_if.kbd_nextdata_n === 1'b0);
            if (press_pulse === 1'b1) begin
                press_t p;
                n_pulses++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL press_unexpected: pulse with code %02h, expected no press", key_code);
                end else begin
                    p = exp_q.pop_front();
                    if (key_code !== p.code || key_ext !== p.ext || key_ascii !== p.ascii ||
                        press_count !== p.cnt || key_valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL press_fields: got code %02h ext %0b ascii %02h cnt %0d valid %0b, expected %02h %0b %02h %0d 1",
                                 key_code, key_ext, key_ascii, press_count, key_valid,
                                 p.code, p.ext, p.ascii, p.cnt);
                    end
                end
            end
        end
    end

    // Called just after a negedge; returns at the negedge where the pop strobe is seen.
    task automatic send_byte(input logic [7:0] b, input logic keep_ready);
        int t;
        model_byte(b);
        kbd_if.kbd_data  = b;
        kbd_if.kbd_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (kbd_if.kbd_nextdata_n !== 1'b0 && t < 20);
        if (kbd_if.kbd_nextdata_n !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_timeout: byte %02h not popped within 20 cycles", b);
        end
        if (!keep_ready) kbd_if.kbd_ready = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        kbd_if.kbd_ready    = 1'b0;
        kbd_if.kbd_overflow = 1'b0;
        kbd_if.kbd_data     = 8'h00;
        repeat (2) @(negedge clk);
        model_reset();
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (kbd_if.kbd_nextdata_n !== 1'b1 || key_code !== 8'h00 || key_ext !== 1'b0 ||
            key_ascii !== 8'h00 || key_valid !== 1'b0 || press_pulse !== 1'b0 ||
            press_count !== 8'h00 || ovf_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: nd_n %0b code %02h ext %0b ascii %02h valid %0b pulse %0b cnt %0d ovf %0b, expected 1 00 0 00 0 0 0 0",
                     kbd_if.kbd_nextdata_n, key_code, key_ext, key_ascii, key_valid,
                     press_pulse, press_count, ovf_sticky);
        end
    endtask

    task automatic test_single_make();
        int pops0;
        do_reset();
        pops0 = n_pops;
        send_byte(8'h1C, 1'b0);
        n_vec++;
        if (key_code !== 8'h1C || key_valid !== 1'b1 || press_count !== 8'd1 ||
            key_ascii !== exp_ascii(8'h1C, 1'b0)) begin
            n_err++;
            $display("FAIL single_make: code %02h valid %0b cnt %0d ascii %02h, expected 1c 1 1 %02h",
                     key_code, key_valid, press_count, key_ascii, exp_ascii(8'h1C, 1'b0));
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (n_pops - pops0 !== 1) begin
            n_err++;
            $display("FAIL single_pop_cycles: nextdata_n low %0d cycles, expected 1", n_pops - pops0);
        end
    endtask

    task automatic test_typematic();
        int pulses0;
        logic [7:0] seq [5];
        do_reset();
        pulses0 = n_pulses;
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        for (int i = 0; i < 5; i++) send_byte(seq[i], 1'b0);
        @(negedge clk);
        n_vec++;
        if (press_count !== 8'd1 || n_pulses - pulses0 !== 1 || key_valid !== 1'b0 || key_code !== 8'h1C) begin
            n_err++;
            $display("FAIL typematic: cnt %0d pulses %0d valid %0b code %02h, expected 1 1 0 1c",
                     press_count, n_pulses - pulses0, key_valid, key_code);
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq [4];
        do_reset();
        seq = '{8'hE0, 8'h75, 8'hF0, 8'h75};
        for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b0);
        n_vec++;
        if (key_ext !== 1'b1 || key_ascii !== 8'h00 || key_valid !== 1'b1 || key_code !== 8'h75) begin
            n_err++;
            $display("FAIL ext_plain_break: ext %0b ascii %02h valid %0b code %02h, expected 1 00 1 75",
                     key_ext, key_ascii, key_valid, key_code);
        end
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        n_vec++;
        if (key_valid !== 1'b0 || key_ext !== 1'b1 || key_code !== 8'h75) begin
            n_err++;
            $display("FAIL ext_break: valid %0b ext %0b code %02h, expected 0 1 75",
                     key_valid, key_ext, key_code);
        end
        send_byte(8'h5A, 1'b0);
        send_byte(8'h29, 1'b0);
        n_vec++;
        if (key_valid !== 1'b1 || key_code !== 8'h29 || press_count !== 8'd3) begin
            n_err++;
            $display("FAIL replace_make: valid %0b code %02h cnt %0d, expected 1 29 3",
                     key_valid, key_code, press_count);
        end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h5A, 1'b0);
        n_vec++;
        if (key_valid !== 1'b1 || key_code !== 8'h29) begin
            n_err++;
            $display("FAIL stale_break: valid %0b code %02h, expected 1 29", key_valid, key_code);
        end
    endtask

    task automatic test_wrap();
        int pulses0;
        do_reset();
        pulses0 = n_pulses;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h16, 1'b0);
            send_byte(8'hF0, 1'b0);
            send_byte(8'h16, 1'b0);
        end
        @(negedge clk);
        n_vec++;
        if (press_count !== 8'd0 || n_pulses - pulses0 !== 256) begin
            n_err++;
            $display("FAIL count_wrap: cnt %0d pulses %0d, expected 0 256",
                     press_count, n_pulses - pulses0);
        end
    endtask

    task automatic test_back_to_back();
        int t_prev;
        logic [7:0] seq [6];
        do_reset();
        seq = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32};
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(seq[i], 1'b1);
            if (i > 0) begin
                n_vec++;
                if (cyc - t_prev !== 3) begin
                    n_err++;
                    $display("FAIL stream_spacing: byte %0d pop spacing %0d cycles, expected 3", i, cyc - t_prev);
                end
            end
            t_prev = cyc;
        end
        kbd_if.kbd_ready = 1'b0;
        n_vec++;
        if (ovf_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_before: ovf_sticky %0b, expected 0", ovf_sticky);
        end
        kbd_if.kbd_overflow = 1'b1;
        @(negedge clk);
        kbd_if.kbd_overflow = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h24, 1'b0);
        n_vec++;
        if (ovf_sticky !== 1'b1 || press_count !== 8'd3) begin
            n_err++;
            $display("FAIL ovf_sticky: ovf %0b cnt %0d, expected 1 3", ovf_sticky, press_count);
        end
        do_reset();
        n_vec++;
        if (ovf_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_reset: ovf_sticky %0b, expected 0", ovf_sticky);
        end
    endtask

    task automatic test_reset_mid_ack();
        do_reset();
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        #1 resetn = 1'b0;
        #1;
        n_vec++;
        if (kbd_if.kbd_nextdata_n !== 1'b1 || key_valid !== 1'b0 || press_count !== 8'd0 ||
            key_code !== 8'h00 || key_ascii !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: nd_n %0b valid %0b cnt %0d code %02h ascii %02h, expected 1 0 0 00 00",
                     kbd_if.kbd_nextdata_n, key_valid, press_count, key_code, key_ascii);
        end
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send_byte(8'h1C, 1'b0);
        n_vec++;
        if (press_count !== 8'd1 || key_valid !== 1'b1 || key_code !== 8'h1C) begin
            n_err++;
            $display("FAIL prefix_lost: cnt %0d valid %0b code %02h, expected 1 1 1c",
                     press_count, key_valid, key_code);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_pops = 0; n_pulses = 0; cyc = 0; prev_low = 1'b0;
        resetn = 1'b0;
        kbd_if.kbd_data = 8'h00; kbd_if.kbd_ready = 1'b0; kbd_if.kbd_overflow = 1'b0;
        model_reset();
        test_reset();
        test_single_make();
        test_typematic();
        test_extended();
        test_wrap();
        test_back_to_back();
        test_reset_mid_ack();
        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL press_missing: %0d expected presses not seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
